// File: rtl/hs_pkg.sv
// Shared types and constants for the transmit-side handshake arbiter.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_e;

    localparam int unsigned HS_SYNC_STAGES = 2;
    localparam int unsigned HS_TO_CYCLES   = 255;

    // Width of a requester id; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq > 1) ? int'($clog2(nreq)) : 1;
    endfunction

    // Timeout counter width: enough for to_cycles, never below 8 bits.
    function automatic int unsigned cnt_width(input int unsigned to_cycles);
        return (int'($clog2(to_cycles + 1)) > 8) ? int'($clog2(to_cycles + 1)) : 8;
    endfunction

endpackage

// File: rtl/hs_tx_arbiter_if.sv
// Requester and handshake-channel signals of the transmit arbiter.
interface hs_tx_arbiter_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              tx_req;
    logic [N-1:0]      tx_data;
    logic              tx_ack;
    logic              busy;
    logic              timeout;

    // Arbiter side.
    modport master (
        input  req_valid, req_data, tx_ack,
        output grant, done, tx_req, tx_data, busy, timeout
    );

    // Requester / receiver side.
    modport slave (
        output req_valid, req_data, tx_ack,
        input  grant, done, tx_req, tx_data, busy, timeout
    );
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the incoming bit one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= '0;
        else      chain_q <= chain_d;
    end

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/hs_tx_arbiter.sv
// Round-robin arbiter feeding one 4-phase req/ack channel toward clk_r.
module hs_tx_arbiter
    import hs_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned SYNC_STAGES = HS_SYNC_STAGES,
    parameter int unsigned TO_CYCLES   = HS_TO_CYCLES
) (
    input  logic             clk_t,
    input  logic             rst,
    hs_tx_arbiter_if.master  bus
);
    localparam int unsigned IDW = id_width(NREQ);
    localparam int unsigned CW  = cnt_width(TO_CYCLES);

    hs_state_e         state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [N-1:0]      tx_data_q, tx_data_d;
    logic              tx_req_q, tx_req_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              abort_q, abort_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              ack_s;
    logic [NREQ-1:0]   grant_c;
    logic [IDW-1:0]    win_id_c;
    logic [N-1:0]      win_data_c;
    logic              win_any_c;

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk_t),
        .rst (rst),
        .d   (bus.tx_ack),
        .q   (ack_s)
    );

    // Round-robin pick: first valid requester at or above ptr, wrapping; only in IDLE with ack low.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        grant_c    = '0;
        win_id_c   = '0;
        win_any_c  = 1'b0;
        if (state_q == IDLE && !ack_s) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!win_any_c && bus.req_valid[IDW'(idx)]) begin
                    win_any_c = 1'b1;
                    win_id_c  = IDW'(idx);
                end
            end
        end
        if (win_any_c) grant_c[win_id_c] = 1'b1;
        win_data_c = N'(bus.req_data >> (32'(win_id_c) * N));
    end

    // Handshake sequencer: next state, captured word, counter and pulses.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        abort_d   = abort_q;
        cnt_d     = '0;
        done_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any_c) begin
                    state_d   = REQ;
                    tx_data_d = win_data_c;
                    owner_d   = win_id_c;
                    abort_d   = 1'b0;
                    ptr_d     = (win_id_c == IDW'(NREQ - 1)) ? '0 : win_id_c + IDW'(1);
                end
            end
            REQ: begin
                if (ack_s || cnt_q == CW'(TO_CYCLES)) begin
                    state_d = REL;
                    abort_d = (cnt_q == CW'(TO_CYCLES));
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    timeout_d = (cnt_q == CW'(TO_CYCLES - 1));
                end
            end
            REL: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    if (!abort_q) done_d[owner_q] = 1'b1;
                end else if (cnt_q == CW'(TO_CYCLES)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    timeout_d = (cnt_q == CW'(TO_CYCLES - 1));
                end
            end
            default: state_d = IDLE;
        endcase
        tx_req_d = (state_d == REQ);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_t or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant   = grant_c;
    assign bus.done    = done_q;
    assign bus.tx_req  = tx_req_q;
    assign bus.tx_data = tx_data_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Directed bench for hs_tx_arbiter with a configurable receiver model.
module tb_hs_tx_arbiter;
    localparam int unsigned N    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TO   = 20;

    logic clk_t = 1'b0;
    logic rst;
    always #5 clk_t = ~clk_t;

    hs_tx_arbiter_if #(.N(N), .NREQ(NREQ)) bus();

    hs_tx_arbiter #(
        .N(N), .NREQ(NREQ), .SYNC_STAGES(SYNC), .TO_CYCLES(TO)
    ) dut (
        .clk_t (clk_t),
        .rst   (rst),
        .bus   (bus)
    );

    // Receiver: 0 = zero-delay echo, 1 = echo 10 cycles late, 2 = forced level.
    int unsigned rx_mode    = 0;
    logic        forced_ack = 1'b0;
    logic [15:0] ack_dly    = '0;
    always @(posedge clk_t) ack_dly <= {ack_dly[14:0], bus.tx_req};
    assign bus.tx_ack = (rx_mode == 0) ? bus.tx_req :
                        (rx_mode == 1) ? ack_dly[9] : forced_ack;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_t);
        #1;
    endtask

    logic [7:0] lane [4];
    int         id;
    logic [7:0] exp_d;

    initial begin
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) @(posedge clk_t);
        #1;
        chk("rst_tx_req",  32'(bus.tx_req),  0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_done",    32'(bus.done),    0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_grant",   32'(bus.grant),   0);
        rst = 1'b1;
        cyc(); cyc();

        // Single transfer, zero-delay receiver.
        bus.req_data  = 32'h0000_00A5;
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_grant", 32'(bus.grant), 32'h1);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("t1_tx_req_c1",  32'(bus.tx_req),  1);
        chk("t1_tx_data_c1", 32'(bus.tx_data), 32'hA5);
        chk("t1_busy_c1",    32'(bus.busy),    1);
        chk("t1_grant_c1",   32'(bus.grant),   0);
        for (int c = 2; c <= 6; c++) begin
            cyc();
            chk($sformatf("t1_busy_c%0d", c),    32'(bus.busy),    1);
            chk($sformatf("t1_done_c%0d", c),    32'(bus.done),    0);
            chk($sformatf("t1_tx_req_c%0d", c),  32'(bus.tx_req),  (c < 4) ? 1 : 0);
            chk($sformatf("t1_tx_data_c%0d", c), 32'(bus.tx_data), 32'hA5);
        end
        cyc();
        chk("t1_done_c7", 32'(bus.done), 32'h1);
        chk("t1_busy_c7", 32'(bus.busy), 0);
        cyc();
        chk("t1_done_c8", 32'(bus.done), 0);

        // Round-robin with all requesters held; pointer starts at 0 after reset.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) lane[i] = 8'(8'h10 + i);
        bus.req_data  = {lane[3], lane[2], lane[1], lane[0]};
        bus.req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            id = t % 4;
            #1;
            chk($sformatf("rr%0d_grant", t), 32'(bus.grant), 32'(1) << id);
            exp_d = lane[id];
            cyc();
            chk($sformatf("rr%0d_tx_data", t), 32'(bus.tx_data), 32'(exp_d));
            chk($sformatf("rr%0d_tx_req", t),  32'(bus.tx_req),  1);
            lane[id]     = lane[id] + 8'h40;
            bus.req_data = {lane[3], lane[2], lane[1], lane[0]};
            if (t == 4) bus.req_valid = '0;
            repeat (5) cyc();
            chk($sformatf("rr%0d_hold", t),  32'(bus.tx_data), 32'(exp_d));
            chk($sformatf("rr%0d_done6", t), 32'(bus.done),    0);
            cyc();
            chk($sformatf("rr%0d_done7", t), 32'(bus.done), 32'(1) << id);
        end

        // Receiver echoes both edges 10 cycles late; pointer is 1, so requester 2 wins.
        repeat (12) cyc();
        rx_mode       = 1;
        bus.req_data  = 32'h003C_0000;
        bus.req_valid = 4'b0100;
        #1;
        chk("dly_grant", 32'(bus.grant), 32'h4);
        for (int c = 1; c <= 26; c++) begin
            cyc();
            if (c == 1) bus.req_valid = '0;
            chk($sformatf("dly_tx_req_c%0d", c),  32'(bus.tx_req),  (c <= 13) ? 1 : 0);
            chk($sformatf("dly_tx_data_c%0d", c), 32'(bus.tx_data), 32'h3C);
            chk($sformatf("dly_busy_c%0d", c),    32'(bus.busy),    1);
            chk($sformatf("dly_done_c%0d", c),    32'(bus.done),    0);
        end
        cyc();
        chk("dly_done_c27", 32'(bus.done), 32'h4);
        chk("dly_busy_c27", 32'(bus.busy), 0);

        // Ack stuck low: timeout in REQ, forced release, no done.
        rx_mode       = 2;
        forced_ack    = 1'b0;
        bus.req_data  = 32'hE700_0000;
        bus.req_valid = 4'b1000;
        #1;
        chk("to_grant", 32'(bus.grant), 32'h8);
        for (int c = 1; c <= 22; c++) begin
            cyc();
            if (c == 1) bus.req_valid = '0;
            chk($sformatf("to_timeout_c%0d", c), 32'(bus.timeout), (c == 21) ? 1 : 0);
            chk($sformatf("to_tx_req_c%0d", c),  32'(bus.tx_req),  (c <= 21) ? 1 : 0);
            chk($sformatf("to_done_c%0d", c),    32'(bus.done),    0);
        end
        cyc();
        chk("to_done_c23",    32'(bus.done),    0);
        chk("to_busy_c23",    32'(bus.busy),    0);
        chk("to_timeout_c23", 32'(bus.timeout), 0);
        rx_mode       = 0;
        bus.req_data  = 32'h0000_005A;
        bus.req_valid = 4'b0001;
        #1;
        chk("to_next_grant", 32'(bus.grant), 32'h1);
        cyc();
        bus.req_valid = '0;
        chk("to_next_data", 32'(bus.tx_data), 32'h5A);
        repeat (6) cyc();
        chk("to_next_done", 32'(bus.done), 32'h1);

        // Stale ack high in IDLE blocks the grant until ack_s falls.
        rx_mode    = 2;
        forced_ack = 1'b1;
        repeat (3) cyc();
        bus.req_data  = 32'h0000_6B00;
        bus.req_valid = 4'b0010;
        #1;
        chk("stale_grant_a", 32'(bus.grant), 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("stale_grant_h%0d", c), 32'(bus.grant), 0);
            chk($sformatf("stale_busy_h%0d", c),  32'(bus.busy),  0);
        end
        forced_ack = 1'b0;
        #1;
        chk("stale_grant_y0", 32'(bus.grant), 0);
        cyc();
        chk("stale_grant_y1", 32'(bus.grant), 0);
        cyc();
        chk("stale_grant_y2", 32'(bus.grant), 32'h2);
        rx_mode = 0;
        cyc();
        bus.req_valid = '0;
        chk("stale_tx_data", 32'(bus.tx_data), 32'h6B);
        chk("stale_tx_req",  32'(bus.tx_req),  1);
        repeat (6) cyc();
        chk("stale_done", 32'(bus.done), 32'h2);

        // Reset during REQ: everything clears asynchronously, pointer returns to 0.
        bus.req_data  = 32'h0000_C300;
        bus.req_valid = 4'b0010;
        #1;
        chk("mid_grant", 32'(bus.grant), 32'h2);
        cyc();
        bus.req_valid = '0;
        chk("mid_tx_req_pre", 32'(bus.tx_req), 1);
        chk("mid_busy_pre",   32'(bus.busy),   1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_tx_req",  32'(bus.tx_req),  0);
        chk("mid_busy",    32'(bus.busy),    0);
        chk("mid_tx_data", 32'(bus.tx_data), 0);
        chk("mid_done",    32'(bus.done),    0);
        chk("mid_timeout", 32'(bus.timeout), 0);
        cyc();
        rst = 1'b1;
        cyc();
        bus.req_data  = 32'h0099_0011;
        bus.req_valid = 4'b0101;
        #1;
        chk("post_grant0", 32'(bus.grant), 32'h1);
        cyc();
        bus.req_valid = 4'b0100;
        chk("post_tx_data0", 32'(bus.tx_data), 32'h11);
        repeat (6) cyc();
        chk("post_done0", 32'(bus.done), 32'h1);
        #1;
        chk("post_grant2", 32'(bus.grant), 32'h4);
        cyc();
        bus.req_valid = '0;
        chk("post_tx_data2", 32'(bus.tx_data), 32'h99);
        repeat (6) cyc();
        chk("post_done2", 32'(bus.done), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hs_tx_arbiter.md
Name: hs_tx_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the clk_t→clk_r 4-phase handshake channel.
- Accepts transfer requests from NREQ clk_t-domain requesters and serialises them onto one tx_req/tx_data/tx_ack channel toward the receiver domain.
- Runs one 4-phase handshake per granted word; reports completion per requester, and reports a timeout if the receiver does not respond.

Parameters:
- N, 8, data word width.
- NREQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flops in the tx_ack synchroniser (>=2).
- TO_CYCLES, 255, max clk_t cycles waiting on one ack edge before timeout.

Ports:
- clk_t  in  1  transmit-domain clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; level, held until granted.
- req_data  in  NREQ*N  requester i data at bits [i*N +: N].
- grant  out  NREQ  one-hot, combinational; transfer accepted when req_valid[i]&grant[i].
- done  out  NREQ  one-cycle pulse to the owner when its handshake completes.
- tx_req  out  1  handshake request to the clk_r domain; registered.
- tx_data  out  N  registered data word, stable from tx_req rise until return to IDLE.
- tx_ack  in  1  asynchronous ack from the clk_r domain.
- busy  out  1  high whenever state != IDLE.
- timeout  out  1  one-cycle pulse when a wait exceeds TO_CYCLES.

Behaviour:
- Reset (rst=0, async): state=IDLE; tx_req=0; tx_data=0; done=0; timeout=0; RR pointer=0; sync chain=0; timeout counter=0.
- ack_s is tx_ack after SYNC_STAGES flops. The FSM uses only ack_s.
- IDLE:
  - grant = first set req_valid bit searching upward from ptr, wrapping modulo NREQ.
  - grant = 0 if req_valid = 0, and grant = 0 in every other state.
  - On acceptance: capture req_data of winner into tx_data, record owner id, set ptr = owner+1 (mod NREQ), go to REQ.
  - IDLE is also gated on ack_s=0. If ack_s=1 in IDLE, no grant is issued.
- REQ: tx_req=1. When ack_s=1, go to REL.
- REL: tx_req=0. When ack_s=0, go to IDLE and pulse done[owner] in the first IDLE cycle.
- Latency with a zero-delay receiver (tx_ack = tx_req):
  - Accept in cycle 0; tx_req rises in cycle 1.
  - REL entered in cycle SYNC_STAGES+2; IDLE/done in cycle 2*SYNC_STAGES+3.
  - Next accept is possible in that same cycle (back-to-back period 2*SYNC_STAGES+3 = 7 at default).
- Timeout:
  - An 8-bit-min counter clears on every state change and increments in REQ/REL.
  - If it reaches TO_CYCLES in REQ: pulse timeout, go to REL (tx_req drops). done is not pulsed for that owner.
  - If it reaches TO_CYCLES in REL: pulse timeout, restart the counter, stay in REL.
- Simultaneous requests: exactly one grant. The ptr ensures no requester is granted twice while another valid requester waits.
- req_valid dropping before grant is legal; it withdraws the request.
- tx_data must not change between acceptance and return to IDLE.
- Reset mid-transfer: tx_req drops immediately and the transfer is lost, with no done or timeout. The receiver must tolerate a req fall without a prior ack.

Decomposition:
- Shared package hs_pkg:
  - state typedef (IDLE, REQ, REL), 2-bit encoding.
  - default SYNC_STAGES and TO_CYCLES constants.
  - function for owner-id width, $clog2(NREQ) with a minimum of 1.
- Sub-module sync_bit (parameter STAGES): async-reset, active-low flop chain, reused by the receiver side.
- RR select is in-line combinational logic.

Test Plan:
- Single transfer: N=8, req_valid=4'b0001, req_data[7:0]=8'hA5, receiver echoes tx_req with 0 delay -> grant[0] in cycle 0; tx_data=8'hA5 and tx_req=1 in cycle 1; done[0] pulse in cycle 7; busy high cycles 1-6.
- Round-robin fairness: req_valid=4'b1111 held with reloaded data -> grant order 0,1,2,3,0; one done per transfer, 7 cycles apart.
- Receiver delay: ack echoed 10 cycles late on both edges -> tx_req high until ack_s rises; tx_data stable throughout; done only after ack_s falls.
- Timeout: TO_CYCLES=20, tx_ack stuck 0 -> timeout pulse 20 cycles after REQ entry; tx_req falls next cycle; no done; FSM returns to IDLE and the next grant proceeds.
- Stale ack: tx_ack held 1 while IDLE with req_valid=4'b0010 -> grant=0 until ack_s=0, then grant[1].
- Reset mid-op: rst low during REQ -> tx_req, busy, tx_data, done all 0 asynchronously; after release ptr=0, requester 0 wins first.
